// File: rtl/gp_register_file_pkg.sv
// Shared encodings and the sub-register merge contract for the general-purpose register file.
// The merge is defined once here, on a wide word, so every user agrees on the x86-style semantics.
package gp_regfile_pkg;

  localparam int MERGE_MAX_W = 64;

  typedef enum logic [1:0] {
    MODE_FULL  = 2'd0,
    MODE_LOW16 = 2'd1,
    MODE_LOW8  = 2'd2,
    MODE_HIGH8 = 2'd3
  } wr_mode_e;

  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_PUSH = 2'd1,
    SP_POP  = 2'd2,
    SP_RSVD = 2'd3
  } sp_op_e;

  typedef logic [MERGE_MAX_W-1:0] merge_word_t;

  // high8 takes its source from data[7:0], matching x86 AH/BH style writes
  function automatic merge_word_t merge_word(merge_word_t old_value, merge_word_t data,
                                             wr_mode_e mode);
    merge_word_t result;
    result = old_value;
    case (mode)
      MODE_FULL:  result        = data;
      MODE_LOW16: result[15:0]  = data[15:0];
      MODE_LOW8:  result[7:0]   = data[7:0];
      MODE_HIGH8: result[15:8]  = data[7:0];
      default:    result        = old_value;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/gp_register_file_if.sv
// Write/read/stack-pointer bundle between decode/execute and the register file.
interface gp_register_file_if
  import gp_regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
);

  logic             wr_en;
  logic [SEL_W-1:0] wr_sel;
  wr_mode_e         wr_mode;
  logic [WIDTH-1:0] write_data;
  sp_op_e           sp_op;
  logic [SEL_W-1:0] rd_sel_a;
  logic [SEL_W-1:0] rd_sel_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic [WIDTH-1:0] sp;
  logic             sel_err;

  modport master (
    output wr_en, wr_sel, wr_mode, write_data, sp_op, rd_sel_a, rd_sel_b,
    input  rd_data_a, rd_data_b, sp, sel_err
  );

  modport slave (
    input  wr_en, wr_sel, wr_mode, write_data, sp_op, rd_sel_a, rd_sel_b,
    output rd_data_a, rd_data_b, sp, sel_err
  );

endinterface

// File: rtl/gp_register_file_merge.sv
// Combinational sub-register merge: narrows the package's wide merge to the register width.
module gp_write_merge
  import gp_regfile_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] old_value,
  input  logic [WIDTH-1:0] data,
  input  wr_mode_e         mode,
  output logic [WIDTH-1:0] merged
);

  assign merged = WIDTH'(merge_word(MERGE_MAX_W'(old_value), MERGE_MAX_W'(data), mode));

endmodule

// File: rtl/gp_register_file.sv
// Array of NUM_REGS general-purpose registers with sub-register writes, stack-pointer
// push/pop and two read ports that can optionally show the next-state value.
module gp_register_file
  import gp_regfile_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               NUM_REGS   = 8,
  parameter int               SEL_W      = 4,
  parameter int               SP_INDEX   = 4,
  parameter logic [WIDTH-1:0] SP_RESET   = WIDTH'(32'h0000_0FFC),
  parameter int               WORD_BYTES = 4,
  parameter int               BYPASS     = 1
) (
  input logic clock_6,
  input logic reset,
  gp_register_file_if.slave bus
);

  logic [WIDTH-1:0] regs      [NUM_REGS];
  logic [WIDTH-1:0] next_regs [NUM_REGS];
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] sp_adjusted;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             wr_in_range;
  logic             sel_err_q;

  // The single merge instance feeds both the registered write and the bypassed reads
  gp_write_merge #(
    .WIDTH(WIDTH)
  ) u_merge (
    .old_value(wr_old),
    .data     (bus.write_data),
    .mode     (bus.wr_mode),
    .merged   (wr_merged)
  );

  always_comb begin
    wr_old      = '0;
    wr_in_range = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.wr_sel == SEL_W'(i)) begin
        wr_old      = regs[i];
        wr_in_range = 1'b1;
      end
    end
  end

  // Write is applied after the SP adjust so a same-edge write to SP overrides push/pop
  always_comb begin
    sp_adjusted = regs[SP_INDEX];
    case (bus.sp_op)
      SP_PUSH: sp_adjusted = regs[SP_INDEX] - WIDTH'(WORD_BYTES);
      SP_POP:  sp_adjusted = regs[SP_INDEX] + WIDTH'(WORD_BYTES);
      default: sp_adjusted = regs[SP_INDEX];
    endcase
    for (int i = 0; i < NUM_REGS; i++) begin
      next_regs[i] = regs[i];
    end
    next_regs[SP_INDEX] = sp_adjusted;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.wr_en && wr_in_range && (bus.wr_sel == SEL_W'(i))) begin
        next_regs[i] = wr_merged;
      end
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_sel_a == SEL_W'(i)) begin
        rd_a = (BYPASS != 0) ? next_regs[i] : regs[i];
      end
      if (bus.rd_sel_b == SEL_W'(i)) begin
        rd_b = (BYPASS != 0) ? next_regs[i] : regs[i];
      end
    end
  end

  always_ff @(posedge clock_6) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
      sel_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= next_regs[i];
      end
      sel_err_q <= bus.wr_en && !wr_in_range;
    end
  end

  assign bus.rd_data_a = rd_a;
  assign bus.rd_data_b = rd_b;
  assign bus.sp        = regs[SP_INDEX];
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_gp_register_file.sv
// Bench for gp_register_file: a bypassing and a non-bypassing instance driven in lockstep,
// checked against a reference model through an expectation queue plus directed value checks.
module tb_gp_register_file;
  import gp_regfile_pkg::*;

  logic clock_6 = 1'b0;
  logic reset   = 1'b1;

  always #5 clock_6 = ~clock_6;

  gp_register_file_if #(.WIDTH(32), .SEL_W(4)) bus_byp ();
  gp_register_file_if #(.WIDTH(32), .SEL_W(4)) bus_reg ();

  gp_register_file #(.BYPASS(1)) dut_byp (
    .clock_6(clock_6),
    .reset  (reset),
    .bus    (bus_byp.slave)
  );

  gp_register_file #(.BYPASS(0)) dut_reg (
    .clock_6(clock_6),
    .reset  (reset),
    .bus    (bus_reg.slave)
  );

  typedef enum int {
    SIG_RDA_BYP, SIG_RDB_BYP, SIG_RDA_REG, SIG_RDB_REG,
    SIG_SP_BYP, SIG_SP_REG, SIG_ERR_BYP, SIG_ERR_REG
  } sig_e;

  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] value;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_regs [8];
  logic        m_sel_err = 1'b0;
  bit          known = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] model_merge(input logic [31:0] o, input logic [31:0] d,
                                              input logic [1:0] mode);
    case (mode)
      2'd0:    return d;
      2'd1:    return {o[31:16], d[15:0]};
      2'd2:    return {o[31:8], d[7:0]};
      default: return {o[31:16], d[7:0], o[7:0]};
    endcase
  endfunction

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      SIG_RDA_BYP: return bus_byp.rd_data_a;
      SIG_RDB_BYP: return bus_byp.rd_data_b;
      SIG_RDA_REG: return bus_reg.rd_data_a;
      SIG_RDB_REG: return bus_reg.rd_data_b;
      SIG_SP_BYP:  return bus_byp.sp;
      SIG_SP_REG:  return bus_reg.sp;
      SIG_ERR_BYP: return {31'd0, bus_byp.sel_err};
      default:     return {31'd0, bus_reg.sel_err};
    endcase
  endfunction

  // Drives one cycle at the negedge, queues the model's expectations, then drains them
  task automatic applyStimulus(input bit rst, input bit en, input logic [3:0] sel,
                               input logic [1:0] mode, input logic [31:0] data,
                               input logic [1:0] spop, input logic [3:0] sa,
                               input logic [3:0] sb);
    logic [31:0] nxt [8];
    exp_t        e;
    @(negedge clock_6);
    reset              = rst;
    bus_byp.wr_en      = en;       bus_reg.wr_en      = en;
    bus_byp.wr_sel     = sel;      bus_reg.wr_sel     = sel;
    bus_byp.wr_mode    = wr_mode_e'(mode); bus_reg.wr_mode = wr_mode_e'(mode);
    bus_byp.write_data = data;     bus_reg.write_data = data;
    bus_byp.sp_op      = sp_op_e'(spop);   bus_reg.sp_op   = sp_op_e'(spop);
    bus_byp.rd_sel_a   = sa;       bus_reg.rd_sel_a   = sa;
    bus_byp.rd_sel_b   = sb;       bus_reg.rd_sel_b   = sb;
    nxt = m_regs;
    if (spop == 2'd1) nxt[4] = m_regs[4] - 32'd4;
    else if (spop == 2'd2) nxt[4] = m_regs[4] + 32'd4;
    if (en && sel < 4'd8) nxt[sel[2:0]] = model_merge(m_regs[sel[2:0]], data, mode);
    if (known) begin
      exp_q.push_back('{"rd_a bypass", SIG_RDA_BYP, (sa < 4'd8) ? nxt[sa[2:0]] : 32'd0});
      exp_q.push_back('{"rd_b bypass", SIG_RDB_BYP, (sb < 4'd8) ? nxt[sb[2:0]] : 32'd0});
      exp_q.push_back('{"rd_a plain", SIG_RDA_REG, (sa < 4'd8) ? m_regs[sa[2:0]] : 32'd0});
      exp_q.push_back('{"rd_b plain", SIG_RDB_REG, (sb < 4'd8) ? m_regs[sb[2:0]] : 32'd0});
      exp_q.push_back('{"sp bypass", SIG_SP_BYP, m_regs[4]});
      exp_q.push_back('{"sp plain", SIG_SP_REG, m_regs[4]});
      exp_q.push_back('{"sel_err bypass", SIG_ERR_BYP, {31'd0, m_sel_err}});
      exp_q.push_back('{"sel_err plain", SIG_ERR_REG, {31'd0, m_sel_err}});
    end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput(e.tag, sample(e.sig), e.value);
    end
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = (i == 4) ? 32'h0000_0FFC : 32'd0;
      m_sel_err = 1'b0;
      known     = 1'b1;
    end else begin
      m_regs    = nxt;
      m_sel_err = en && (sel >= 4'd8);
    end
  endtask

  task automatic idleRead(input logic [3:0] sa, input logic [3:0] sb);
    applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, 32'd0, 2'd0, sa, sb);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 4'd0, 2'd0, 32'd0, 2'd0, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      idleRead(4'(i), 4'(7 - i));
      checkOutput("reset contents", bus_reg.rd_data_a, (i == 4) ? 32'h0000_0FFC : 32'd0);
    end
    checkOutput("reset sp", bus_byp.sp, 32'h0000_0FFC);
    checkOutput("reset sel_err", {31'd0, bus_byp.sel_err}, 32'd0);

    applyStimulus(1'b0, 1'b1, 4'd0, MODE_FULL, 32'h1234_5678, 2'd0, 4'd0, 4'd0);
    checkOutput("full write bypass", bus_byp.rd_data_a, 32'h1234_5678);
    checkOutput("full write old value", bus_reg.rd_data_a, 32'd0);
    applyStimulus(1'b0, 1'b1, 4'd0, MODE_LOW8, 32'h0000_00AB, 2'd0, 4'd0, 4'd0);
    checkOutput("low8 merge", bus_byp.rd_data_a, 32'h1234_56AB);
    applyStimulus(1'b0, 1'b1, 4'd0, MODE_HIGH8, 32'hFFFF_FFCD, 2'd0, 4'd0, 4'd0);
    checkOutput("high8 merge", bus_byp.rd_data_a, 32'h1234_CDAB);
    applyStimulus(1'b0, 1'b1, 4'd0, MODE_LOW16, 32'h5555_BEEF, 2'd0, 4'd0, 4'd0);
    checkOutput("low16 merge", bus_byp.rd_data_a, 32'h1234_BEEF);
    idleRead(4'd0, 4'd4);
    checkOutput("reg0 stored", bus_reg.rd_data_a, 32'h1234_BEEF);

    applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, 32'd0, SP_PUSH, 4'd4, 4'd4);
    applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, 32'd0, SP_PUSH, 4'd4, 4'd4);
    idleRead(4'd4, 4'd4);
    checkOutput("push twice", bus_byp.sp, 32'h0000_0FF4);
    applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, 32'd0, SP_POP, 4'd4, 4'd4);
    idleRead(4'd4, 4'd4);
    checkOutput("pop", bus_byp.sp, 32'h0000_0FF8);
    applyStimulus(1'b0, 1'b1, 4'd1, MODE_FULL, 32'h0000_0055, SP_PUSH, 4'd1, 4'd4);
    idleRead(4'd1, 4'd4);
    checkOutput("parallel write", bus_reg.rd_data_a, 32'h0000_0055);
    checkOutput("parallel push", bus_reg.sp, 32'h0000_0FF4);

    applyStimulus(1'b0, 1'b1, 4'd4, MODE_FULL, 32'd0, SP_NONE, 4'd4, 4'd4);
    applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, 32'd0, SP_PUSH, 4'd4, 4'd4);
    idleRead(4'd4, 4'd4);
    checkOutput("push wrap", bus_byp.sp, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 4'd0, 2'd0, 32'd0, SP_POP, 4'd4, 4'd4);
    idleRead(4'd4, 4'd4);
    checkOutput("pop wrap", bus_byp.sp, 32'd0);
    applyStimulus(1'b0, 1'b1, 4'd4, MODE_FULL, 32'h0000_0100, SP_PUSH, 4'd4, 4'd4);
    idleRead(4'd4, 4'd4);
    checkOutput("write beats push", bus_byp.sp, 32'h0000_0100);
    applyStimulus(1'b0, 1'b1, 4'd4, MODE_LOW8, 32'h0000_0077, SP_POP, 4'd4, 4'd4);
    idleRead(4'd4, 4'd4);
    checkOutput("low8 beats pop", bus_byp.sp, 32'h0000_0177);

    applyStimulus(1'b0, 1'b1, 4'd3, MODE_FULL, 32'hDEAD_BEEF, SP_NONE, 4'd3, 4'd3);
    checkOutput("bypass same cycle", bus_byp.rd_data_a, 32'hDEAD_BEEF);
    checkOutput("no bypass old", bus_reg.rd_data_a, 32'd0);

    applyStimulus(1'b0, 1'b1, 4'd9, MODE_FULL, 32'hFFFF_FFFF, SP_NONE, 4'd3, 4'd12);
    checkOutput("out of range read", bus_byp.rd_data_b, 32'd0);
    idleRead(4'd3, 4'd0);
    checkOutput("sel_err pulse", {31'd0, bus_reg.sel_err}, 32'd1);
    checkOutput("oor no change", bus_reg.rd_data_a, 32'hDEAD_BEEF);
    idleRead(4'd3, 4'd0);
    checkOutput("sel_err one cycle", {31'd0, bus_reg.sel_err}, 32'd0);

    applyStimulus(1'b0, 1'b1, 4'd2, MODE_FULL, 32'h0000_A5A5, SP_NONE, 4'd2, 4'd4);
    applyStimulus(1'b1, 1'b1, 4'd2, MODE_FULL, 32'h0000_1111, SP_PUSH, 4'd2, 4'd4);
    idleRead(4'd2, 4'd4);
    checkOutput("mid reset reg2", bus_reg.rd_data_a, 32'd0);
    checkOutput("mid reset sp", bus_reg.sp, 32'h0000_0FFC);

    repeat (300) begin
      applyStimulus($urandom_range(0, 40) == 0, 1'($urandom), 4'($urandom_range(0, 9)),
                    2'($urandom), $urandom, 2'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gp_register_file.md
# gp_register_file

Parametrised general-purpose register file that generalises the single-register blocks into one array of NUM_REGS registers. It provides:
- one write port with x86-style sub-register write modes (full, low 16, low 8, high 8);
- dedicated stack-pointer push/pop adjust;
- two read ports with optional write-through bypass.

It sits between the decode/execute stage and the ALU and is clocked on the clock_6 phase.

## Interface
Parameters:
- WIDTH, 32, register width in bits (≥16)
- NUM_REGS, 8, number of registers
- SEL_W, 4, select width (2^SEL_W ≥ NUM_REGS)
- SP_INDEX, 4, index of the stack-pointer register
- SP_RESET, 32'h0000_0FFC, stack-pointer reset value
- WORD_BYTES, 4, push/pop step
- BYPASS, 1, 1 = read ports show next-state value

Ports:
- clock_6  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high; clock clock_6
- wr_en  in  1  write request
- wr_sel  in  SEL_W  destination register index
- wr_mode  in  2  0 full, 1 low16, 2 low8, 3 high8
- write_data  in  WIDTH  write value
- sp_op  in  2  0 none, 1 push, 2 pop, 3 reserved (no-op)
- rd_sel_a, rd_sel_b  in  SEL_W  read indices
- rd_data_a, rd_data_b  out  WIDTH  read data (combinational)
- sp  out  WIDTH  current stack-pointer register contents (never bypassed)
- sel_err  out  1  registered, 1-cycle pulse on an out-of-range write

## Operation
- Reset has priority over all other inputs on the same edge:
  - register SP_INDEX ← SP_RESET; all other registers ← 0;
  - sel_err ← 0.
- Write, when wr_en=1 and wr_sel < NUM_REGS, new value = merge(old, write_data, wr_mode):
  - full: write_data;
  - low16: {old[W-1:16], wd[15:0]};
  - low8: {old[W-1:8], wd[7:0]};
  - high8: {old[W-1:16], wd[7:0], old[7:0]} (the source is wd[7:0]).
- Out-of-range write (wr_en=1, wr_sel ≥ NUM_REGS): no register changes; sel_err=1 on the following cycle only.
- Stack-pointer adjust:
  - push: SP ← SP − WORD_BYTES; pop: SP ← SP + WORD_BYTES;
  - arithmetic is modulo 2^WIDTH (0 pop-from-max wraps, push from 0 gives 2^WIDTH−WORD_BYTES).
- Write and sp_op targeting SP on the same edge: the write wins, in any mode, and sp_op is discarded. A write to any other register proceeds in parallel with sp_op.
- Read ports:
  - index ≥ NUM_REGS returns 0;
  - BYPASS=0: current contents;
  - BYPASS=1: the value the selected register will hold after the coming edge (write merge and sp_op included; reset not bypassed).
- Both read ports may select the same register; no read side effects.

## Timing
- Write latency 1 clock_6 edge; with BYPASS=1 the read-after-write visibility is 0 cycles (combinational).
- sel_err asserts 1 cycle after the offending edge, for exactly one cycle.
- reset asserted mid-stream: that edge applies reset only; concurrent wr_en and sp_op are dropped. The first write accepted is on the edge after reset deasserts.
- No handshake: every cycle accepts one write and one sp_op.
- No multi-cycle paths.

## Structure
- Package gp_regfile_pkg holds:
  - wr_mode encodings MODE_FULL/MODE_LOW16/MODE_LOW8/MODE_HIGH8;
  - sp_op encodings SP_NONE/SP_PUSH/SP_POP;
  - the merge function prototype contract.
- Sub-module gp_write_merge: combinational (old, data, mode) → merged value. It is instantiated once for the write path and reused for bypass computation.
- Register array plus next-state vector computed in one combinational block; a single clocked block applies next-state and reset.

## Test plan
- Reset: assert reset 1 cycle -> all rd_data 0 except index 4 = 0x0000_0FFC; sp=0x0FFC; sel_err=0.
- Sub-register writes:
  - full write 0x1234_5678 to reg 0;
  - then low8 0xAB -> 0x1234_56AB;
  - then high8 0xCD -> 0x1234_CDAB;
  - then low16 0xBEEF -> 0x1234_BEEF.
- SP ops:
  - push twice from reset -> sp=0x0FF4; pop -> 0x0FF8;
  - with SP=0, push -> 0xFFFF_FFFC;
  - same-edge full write 0x100 to SP plus push -> sp=0x100.
- Bypass (BYPASS=1): write 0xDEAD_BEEF to reg 3 with rd_sel_a=3 -> rd_data_a=0xDEAD_BEEF in the same cycle. BYPASS=0 -> old value until the edge.
- Out-of-range: wr_en, wr_sel=9 -> no register changes; sel_err high exactly the next cycle. rd_sel_b=12 -> 0.
- Reset mid-operation: reset with wr_en to reg 2 and push on the same edge -> reg 2=0, sp=0x0FFC.
